// File: rtl/tt_pkg.sv
// Shared types for the truth-table sweeper: FSM state encoding and row-order modes.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tt_state_e;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

endpackage

// File: rtl/tt_row_encoder.sv
// Maps a sweep index to the presented input combination, either straight binary
// or reflected Gray, so consecutive Gray rows differ in exactly one variable.
module tt_row_encoder
  import tt_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0] idx,
  input  logic            mode,
  output logic [N_IN-1:0] row_vars
);

  // Index-to-combination conversion.
  always_comb begin
    row_vars = idx;
    case (mode)
      MODE_BIN:  row_vars = idx;
      MODE_GRAY: row_vars = idx ^ (idx >> 1'd1);
      default:   row_vars = idx;
    endcase
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Streams every row of a latched N_IN-input / N_OUT-output truth table over a
// valid/ready interface and counts the rows where output 0 is true.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic [N_OUT*(2**N_IN)-1:0]   lut_in,
  output logic [N_IN-1:0]              row_vars,
  output logic [N_OUT-1:0]             row_f,
  output logic                         row_valid,
  input  logic                         row_ready,
  output logic                         row_last,
  output logic                         busy,
  output logic                         done,
  output logic [N_IN:0]                ones_count
);

  localparam int              ROWS    = 2**N_IN;
  localparam logic [N_IN-1:0] IDX_MAX = {N_IN{1'b1}};

  tt_state_e         state_r;
  logic [N_IN-1:0]   idx_r;
  logic              mode_r;
  logic [ROWS-1:0]   lut_r [N_OUT];
  logic [N_IN-1:0]   row_vars_r;
  logic [N_OUT-1:0]  row_f_r;
  logic              row_valid_r;
  logic              row_last_r;
  logic              busy_r;
  logic              done_r;
  logic [N_IN:0]     ones_r;

  logic [ROWS-1:0]   lut_in_s [N_OUT];
  logic [N_IN-1:0]   idx_inc_s;
  logic [N_IN-1:0]   next_vars_s;
  logic [N_OUT-1:0]  next_f_s;
  logic [N_OUT-1:0]  start_f_s;

  assign idx_inc_s = idx_r + N_IN'(1'b1);

  // The payload is precomputed for the following row so every output can be a flop.
  tt_row_encoder #(.N_IN(N_IN)) u_encoder (
    .idx      (idx_inc_s),
    .mode     (mode_r),
    .row_vars (next_vars_s)
  );

  // Split the flat table per output and look up the upcoming row.
  always_comb begin
    next_f_s  = '0;
    start_f_s = '0;
    for (int k = 0; k < N_OUT; k++) begin
      lut_in_s[k]  = lut_in[k*ROWS +: ROWS];
      start_f_s[k] = lut_in_s[k][0];
      next_f_s[k]  = lut_r[k][next_vars_s];
    end
  end

  // Sweep FSM with index counter, table capture, registered payload and true-row count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      mode_r      <= MODE_BIN;
      lut_r       <= '{default: '0};
      row_vars_r  <= '0;
      row_f_r     <= '0;
      row_valid_r <= 1'b0;
      row_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ones_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r     <= RUN;
            idx_r       <= '0;
            mode_r      <= mode;
            lut_r       <= lut_in_s;
            // Row 0 is combination 0 in both orders.
            row_vars_r  <= '0;
            row_f_r     <= start_f_s;
            row_valid_r <= 1'b1;
            row_last_r  <= 1'b0;
            busy_r      <= 1'b1;
            ones_r      <= '0;
          end
        end
        RUN: begin
          if (row_ready) begin
            if (row_f_r[0]) begin
              ones_r <= ones_r + (N_IN+1)'(1'b1);
            end
            if (idx_r == IDX_MAX) begin
              state_r     <= DONE;
              row_vars_r  <= '0;
              row_f_r     <= '0;
              row_valid_r <= 1'b0;
              row_last_r  <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              idx_r      <= idx_inc_s;
              row_vars_r <= next_vars_s;
              row_f_r    <= next_f_s;
              row_last_r <= (idx_inc_s == IDX_MAX);
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          row_valid_r <= 1'b0;
          row_last_r  <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign row_vars   = row_vars_r;
  assign row_f      = row_f_r;
  assign row_valid  = row_valid_r;
  assign row_last   = row_last_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign ones_count = ones_r;

endmodule
